// File: rtl/rs_pkg.sv
// rs_pkg
// Shared definitions for the reservation station slice.
//   - default configuration widths of the station
//   - rs_count_w(): width of an occupancy counter able to hold 0..depth
//   - decoded opcode constants, including JALR
//   - per-entry flag struct and the default-width entry layout
// Configuration macro handled by the users of this package: RS_CDB_BYPASS_EN.
package rs_pkg;

  localparam int RS_DEPTH   = 16;
  localparam int RS_XLEN    = 32;
  localparam int RS_TAG_W   = 5;
  localparam int RS_OP_W    = 6;
  localparam int RS_NUM_CDB = 2;

  // Counter has to represent the full value DEPTH, hence depth+1 codes.
  function automatic int rs_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int RS_COUNT_W = rs_count_w(RS_DEPTH);

  localparam logic [RS_OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [RS_OP_W-1:0] OP_SUB  = 6'h01;
  localparam logic [RS_OP_W-1:0] OP_AND  = 6'h02;
  localparam logic [RS_OP_W-1:0] OP_OR   = 6'h03;
  localparam logic [RS_OP_W-1:0] OP_XOR  = 6'h04;
  localparam logic [RS_OP_W-1:0] OP_SLL  = 6'h05;
  localparam logic [RS_OP_W-1:0] OP_SRL  = 6'h06;
  localparam logic [RS_OP_W-1:0] OP_SRA  = 6'h07;
  localparam logic [RS_OP_W-1:0] OP_SLT  = 6'h08;
  localparam logic [RS_OP_W-1:0] OP_BEQ  = 6'h10;
  localparam logic [RS_OP_W-1:0] OP_BNE  = 6'h11;
  localparam logic [RS_OP_W-1:0] OP_JAL  = 6'h18;
  localparam logic [RS_OP_W-1:0] OP_JALR = 6'h19;

  // Control bits of one entry: occupied, operand j pending, operand k pending.
  typedef struct packed {
    logic busy;
    logic qj_v;
    logic qk_v;
  } rs_flags_t;

  // Complete entry layout for the default configuration.
  typedef struct packed {
    rs_flags_t            flags;
    logic [RS_OP_W-1:0]   op;
    logic [RS_XLEN-1:0]   pc;
    logic [RS_XLEN-1:0]   imm;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_TAG_W-1:0]  qk;
    logic [RS_XLEN-1:0]   vj;
    logic [RS_XLEN-1:0]   vk;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix
// DEPTH x DEPTH age matrix picking the oldest ready entry.
// age[j][i] = 1 means entry j is older than entry i.
// Ports:
//   clk, rst (async, active-low), en (0 freezes state)
//   clear       : forget all age relations
//   alloc_valid, alloc_idx : entry allocated this cycle, becomes youngest
//   free_mask   : entries released this cycle
//   ready_mask  : entries eligible for selection
//   oldest      : one-hot oldest entry of ready_mask (zero when none)
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     alloc_valid,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [DEPTH-1:0]         free_mask,
  input  logic [DEPTH-1:0]         ready_mask,
  output logic [DEPTH-1:0]         oldest
);

  logic [DEPTH-1:0] age [DEPTH];

  // A freed entry drops all relations; a newly allocated entry is marked
  // younger than every other slot. Allocation is applied after freeing so a
  // slot freed in the same cycle still ends up older than the new entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (en) begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (free_mask[i]) begin
            age[i] <= '0;
            for (int j = 0; j < DEPTH; j++) age[j][i] <= 1'b0;
          end
        end
        if (alloc_valid) begin
          age[alloc_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != int'(alloc_idx)) age[j][alloc_idx] <= 1'b1;
          end
        end
      end
    end
  end

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = ready_mask[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_mask[j] && age[j][i]) oldest[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// rs_station
// Age-ordered reservation station with multi-port CDB wakeup.
// Ports:
//   clk, rst (async, active-low), rdy (0 freezes everything), flush
//   disp_*   : dispatch handshake and instruction fields (valid/ready)
//   cdb_*    : NUM_CDB broadcast ports, packed port0 in the low bits
//   iss_*    : issue handshake and fields of the oldest ready entry
//   count    : number of occupied entries
// Optional feature: define RS_CDB_BYPASS_EN to capture CDB results for
// operands that are dispatched in the same cycle as their broadcast.
module rs_station
  import rs_pkg::*;
#(
  parameter int DEPTH   = RS_DEPTH,
  parameter int XLEN    = RS_XLEN,
  parameter int TAG_W   = RS_TAG_W,
  parameter int OP_W    = RS_OP_W,
  parameter int NUM_CDB = RS_NUM_CDB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [XLEN-1:0]            disp_pc,
  input  logic [XLEN-1:0]            disp_imm,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic                       disp_qj_v,
  input  logic                       disp_qk_v,
  input  logic [TAG_W-1:0]           disp_qj,
  input  logic [TAG_W-1:0]           disp_qk,
  input  logic [XLEN-1:0]            disp_vj,
  input  logic [XLEN-1:0]            disp_vk,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [XLEN-1:0]            iss_vj,
  output logic [XLEN-1:0]            iss_vk,
  output logic [XLEN-1:0]            iss_imm,
  output logic [XLEN-1:0]            iss_pc,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = rs_count_w(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  rs_flags_t         flags  [DEPTH];
  logic [OP_W-1:0]   ent_op [DEPTH];
  logic [XLEN-1:0]   ent_pc [DEPTH];
  logic [XLEN-1:0]   ent_imm[DEPTH];
  logic [TAG_W-1:0]  ent_tag[DEPTH];
  logic [TAG_W-1:0]  ent_qj [DEPTH];
  logic [TAG_W-1:0]  ent_qk [DEPTH];
  logic [XLEN-1:0]   ent_vj [DEPTH];
  logic [XLEN-1:0]   ent_vk [DEPTH];

  logic [DEPTH-1:0]  ready_mask;
  logic [DEPTH-1:0]  oldest;
  logic [DEPTH-1:0]  free_mask;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire;
  logic              iss_fire;

  logic [DEPTH-1:0]  wake_j, wake_k;
  logic [XLEN-1:0]   wake_vj[DEPTH];
  logic [XLEN-1:0]   wake_vk[DEPTH];

  logic              new_qj_v, new_qk_v;
  logic [XLEN-1:0]   new_vj, new_vk;

  assign disp_ready = rdy && !flush && (count < FULL_COUNT);
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_valid  = rdy && !flush && (|ready_mask);
  assign iss_fire   = iss_valid && iss_ready;
  assign free_mask  = iss_fire ? oldest : '0;

  // Per-entry readiness and lowest free slot; slots being issued this cycle
  // still look busy, so they are not reused until the next cycle.
  always_comb begin
    ready_mask = '0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_mask[i] = flags[i].busy && !flags[i].qj_v && !flags[i].qk_v;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!flags[i].busy) free_idx = IDX_W'(i);
    end
  end

  // Tag compare against every CDB port. Ports are scanned from the highest
  // index down so the lowest matching port overrides.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake_j[i]  = 1'b0;
      wake_k[i]  = 1'b0;
      wake_vj[i] = '0;
      wake_vk[i] = '0;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == ent_qj[i]) begin
          wake_j[i]  = 1'b1;
          wake_vj[i] = cdb_value[p*XLEN +: XLEN];
        end
        if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == ent_qk[i]) begin
          wake_k[i]  = 1'b1;
          wake_vk[i] = cdb_value[p*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef RS_CDB_BYPASS_EN
  // A dispatching operand whose producer broadcasts right now is captured
  // immediately instead of being stored as pending.
  always_comb begin
    new_qj_v = disp_qj_v;
    new_qk_v = disp_qk_v;
    new_vj   = disp_vj;
    new_vk   = disp_vk;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (disp_qj_v && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == disp_qj) begin
        new_qj_v = 1'b0;
        new_vj   = cdb_value[p*XLEN +: XLEN];
      end
      if (disp_qk_v && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == disp_qk) begin
        new_qk_v = 1'b0;
        new_vk   = cdb_value[p*XLEN +: XLEN];
      end
    end
  end
`else
  // Operands are stored exactly as dispatched; same-cycle broadcasts must be
  // forwarded upstream.
  always_comb begin
    new_qj_v = disp_qj_v;
    new_qk_v = disp_qk_v;
    new_vj   = disp_vj;
    new_vk   = disp_vk;
  end
`endif

  // Issue fields come straight from the one-hot oldest ready entry; with no
  // ready entry every field reads zero.
  always_comb begin
    iss_op  = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    iss_pc  = '0;
    iss_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) begin
        iss_op  = ent_op[i];
        iss_vj  = ent_vj[i];
        iss_vk  = ent_vk[i];
        iss_imm = ent_imm[i];
        iss_pc  = ent_pc[i];
        iss_tag = ent_tag[i];
      end
    end
  end

  // Entry storage and occupancy. Flush wins over dispatch, issue and wakeup;
  // wakeup only touches busy entries so it never collides with the slot
  // being written by dispatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        flags[i]   <= '0;
        ent_op[i]  <= '0;
        ent_pc[i]  <= '0;
        ent_imm[i] <= '0;
        ent_tag[i] <= '0;
        ent_qj[i]  <= '0;
        ent_qk[i]  <= '0;
        ent_vj[i]  <= '0;
        ent_vk[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        count <= '0;
        for (int i = 0; i < DEPTH; i++) flags[i].busy <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (free_mask[i]) flags[i].busy <= 1'b0;
          if (flags[i].busy && flags[i].qj_v && wake_j[i]) begin
            flags[i].qj_v <= 1'b0;
            ent_vj[i]     <= wake_vj[i];
          end
          if (flags[i].busy && flags[i].qk_v && wake_k[i]) begin
            flags[i].qk_v <= 1'b0;
            ent_vk[i]     <= wake_vk[i];
          end
        end
        if (disp_fire) begin
          flags[free_idx]   <= '{busy: 1'b1, qj_v: new_qj_v, qk_v: new_qk_v};
          ent_op[free_idx]  <= disp_op;
          ent_pc[free_idx]  <= disp_pc;
          ent_imm[free_idx] <= disp_imm;
          ent_tag[free_idx] <= disp_tag;
          ent_qj[free_idx]  <= disp_qj;
          ent_qk[free_idx]  <= disp_qk;
          ent_vj[free_idx]  <= new_vj;
          ent_vk[free_idx]  <= new_vk;
        end
        if (disp_fire && !iss_fire) count <= count + CW'(1);
        else if (!disp_fire && iss_fire) count <= count - CW'(1);
      end
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk         (clk),
    .rst         (rst),
    .en          (rdy),
    .clear       (flush),
    .alloc_valid (disp_fire),
    .alloc_idx   (free_idx),
    .free_mask   (free_mask),
    .ready_mask  (ready_mask),
    .oldest      (oldest)
  );

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station
// Self-checking bench for rs_station in its default configuration
// (DEPTH=16, XLEN=32, TAG_W=5, OP_W=6, NUM_CDB=2). Expected issues are
// queued in issue order and compared by a monitor whenever an issue fires.
// Honours RS_CDB_BYPASS_EN to choose the expected dispatch-bypass behaviour.
module tb_rs_station;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int OP_W  = 6;
  localparam int NCDB  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rdy;
  logic                   flush;
  logic                   disp_valid;
  logic                   disp_ready;
  logic [OP_W-1:0]        disp_op;
  logic [XLEN-1:0]        disp_pc, disp_imm;
  logic [TAG_W-1:0]       disp_tag;
  logic                   disp_qj_v, disp_qk_v;
  logic [TAG_W-1:0]       disp_qj, disp_qk;
  logic [XLEN-1:0]        disp_vj, disp_vk;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_value;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [OP_W-1:0]        iss_op;
  logic [XLEN-1:0]        iss_vj, iss_vk, iss_imm, iss_pc;
  logic [TAG_W-1:0]       iss_tag;
  logic [CW-1:0]          count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic             rdy;
    logic             disp_valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic             exp_disp_ready;
    logic             exp_iss_valid;
    logic [CW-1:0]    exp_count;
  } vec_t;

  vec_t vecs[18];

  rs_station dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_op    (disp_op),
    .disp_pc    (disp_pc),
    .disp_imm   (disp_imm),
    .disp_tag   (disp_tag),
    .disp_qj_v  (disp_qj_v),
    .disp_qk_v  (disp_qk_v),
    .disp_qj    (disp_qj),
    .disp_qk    (disp_qk),
    .disp_vj    (disp_vj),
    .disp_vk    (disp_vk),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_op     (iss_op),
    .iss_vj     (iss_vj),
    .iss_vk     (iss_vk),
    .iss_imm    (iss_imm),
    .iss_pc     (iss_pc),
    .iss_tag    (iss_tag),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    disp_valid = 1'b0;
    disp_qj_v  = 1'b0;
    disp_qk_v  = 1'b0;
    disp_qj    = '0;
    disp_qk    = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_value  = '0;
    flush      = 1'b0;
  endtask

  // op/pc/imm are derived from the tag so the monitor can predict them.
  task automatic drive_disp(input logic [TAG_W-1:0] tag,
                            input logic qj_v, input logic [TAG_W-1:0] qj, input logic [XLEN-1:0] vj,
                            input logic qk_v, input logic [TAG_W-1:0] qk, input logic [XLEN-1:0] vk);
    disp_valid = 1'b1;
    disp_tag   = tag;
    disp_op    = OP_W'(tag) + 6'd1;
    disp_pc    = 32'h1000 + 32'(tag) * 4;
    disp_imm   = 32'h500 + 32'(tag);
    disp_qj_v  = qj_v;
    disp_qj    = qj;
    disp_vj    = vj;
    disp_qk_v  = qk_v;
    disp_qk    = qk;
    disp_vk    = vk;
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk);
    exp_t e;
    e.tag = tag;
    e.vj  = vj;
    e.vk  = vk;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    rdy = v.rdy;
    drive_disp(v.tag, 1'b0, '0, v.vj, 1'b0, '0, v.vk);
    disp_valid = v.disp_valid;
    if (v.rdy && v.disp_valid && v.exp_disp_ready) push_exp(v.tag, v.vj, v.vk);
    #2;
    checkOutput("vec_disp_ready", 32'(disp_ready), 32'(v.exp_disp_ready));
    checkOutput("vec_iss_valid", 32'(iss_valid), 32'(v.exp_iss_valid));
    step();
    checkOutput("vec_count", 32'(count), 32'(v.exp_count));
  endtask

  task automatic wait_drain(input int max_cycles);
    int c = 0;
    while (sb.size() != 0 && c < max_cycles) begin
      step();
      c++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL drain_timeout: %0d issues outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard side: an issue fires at the coming edge when valid and ready
  // are both high at the falling edge.
  always @(negedge clk) begin
    if (rst && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_issue: got tag %0h, expected no issue", iss_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("iss_tag", 32'(iss_tag), 32'(e.tag));
        checkOutput("iss_vj", iss_vj, e.vj);
        checkOutput("iss_vk", iss_vk, e.vk);
        checkOutput("iss_op", 32'(iss_op), 32'(OP_W'(e.tag) + 6'd1));
        checkOutput("iss_pc", iss_pc, 32'h1000 + 32'(e.tag) * 4);
        checkOutput("iss_imm", iss_imm, 32'h500 + 32'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fill table: 16 independent dispatches, one blocked by full, one frozen.
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i] = '{rdy: 1'b1, disp_valid: 1'b1, tag: TAG_W'(i),
                  vj: 32'h100 + 32'(i), vk: 32'h200 + 32'(i),
                  exp_disp_ready: 1'b1, exp_iss_valid: (i > 0),
                  exp_count: CW'(i + 1)};
    end
    vecs[16] = '{rdy: 1'b1, disp_valid: 1'b1, tag: 5'd16, vj: 32'h0, vk: 32'h0,
                 exp_disp_ready: 1'b0, exp_iss_valid: 1'b1, exp_count: CW'(16)};
    vecs[17] = '{rdy: 1'b0, disp_valid: 1'b1, tag: 5'd17, vj: 32'h0, vk: 32'h0,
                 exp_disp_ready: 1'b0, exp_iss_valid: 1'b0, exp_count: CW'(16)};

    rst       = 1'b0;
    rdy       = 1'b1;
    iss_ready = 1'b0;
    disp_tag  = '0;
    disp_op   = '0;
    disp_pc   = '0;
    disp_imm  = '0;
    disp_vj   = '0;
    disp_vk   = '0;
    drive_idle();
    step();
    step();
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("rst_iss_tag", 32'(iss_tag), 32'd0);
    checkOutput("rst_iss_vj", iss_vj, 32'd0);
    rst = 1'b1;
    step();
    checkOutput("idle_disp_ready", 32'(disp_ready), 32'd1);
    checkOutput("idle_iss_valid", 32'(iss_valid), 32'd0);

    $display("[TB] fill to full, then drain in age order");
    for (int i = 0; i < 18; i++) applyStimulus(vecs[i]);
    rdy = 1'b1;
    drive_idle();
    iss_ready = 1'b1;
    wait_drain(40);
    step();
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_iss_valid", 32'(iss_valid), 32'd0);

    $display("[TB] age order with pending operand and CDB port1 wakeup");
    drive_disp(5'd3, 1'b1, 5'd7, 32'h0, 1'b0, 5'd0, 32'h33);
    step();
    drive_disp(5'd4, 1'b0, 5'd0, 32'h44, 1'b0, 5'd0, 32'h45);
    push_exp(5'd4, 32'h44, 32'h45);
    step();
    drive_disp(5'd12, 1'b0, 5'd0, 32'hC0, 1'b0, 5'd0, 32'hC1);
    push_exp(5'd12, 32'hC0, 32'hC1);
    step();
    checkOutput("disp_and_issue_count", 32'(count), 32'd2);
    drive_idle();
    step();
    checkOutput("pending_count", 32'(count), 32'd1);
    #2;
    checkOutput("pending_no_issue", 32'(iss_valid), 32'd0);
    cdb_valid = 2'b10;
    cdb_tag   = {5'd7, 5'd0};
    cdb_value = {32'h1234, 32'h0};
    push_exp(5'd3, 32'h1234, 32'h33);
    checkOutput("cdb_cycle_no_issue", 32'(iss_valid), 32'd0);
    step();
    drive_idle();
    wait_drain(5);
    step();
    checkOutput("wake_count", 32'(count), 32'd0);

    $display("[TB] two ports broadcast the same tag");
    drive_disp(5'd10, 1'b1, 5'd9, 32'h0, 1'b0, 5'd0, 32'h77);
    step();
    drive_idle();
    #2;
    checkOutput("dual_pending_no_issue", 32'(iss_valid), 32'd0);
    cdb_valid = 2'b11;
    cdb_tag   = {5'd9, 5'd9};
    cdb_value = {32'hB, 32'hA};
    push_exp(5'd10, 32'hA, 32'h77);
    step();
    drive_idle();
    wait_drain(5);

    $display("[TB] dispatch in the same cycle as the producing broadcast");
    drive_disp(5'd11, 1'b0, 5'd0, 32'h11, 1'b1, 5'd5, 32'hDEAD);
    cdb_valid = 2'b01;
    cdb_tag   = {5'd0, 5'd5};
    cdb_value = {32'h0, 32'h55};
`ifdef RS_CDB_BYPASS_EN
    push_exp(5'd11, 32'h11, 32'h55);
    step();
    drive_idle();
    #2;
    checkOutput("bypass_iss_valid", 32'(iss_valid), 32'd1);
    wait_drain(5);
`else
    step();
    drive_idle();
    repeat (4) step();
    checkOutput("nobypass_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("nobypass_count", 32'(count), 32'd1);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_single_count", 32'(count), 32'd0);

    $display("[TB] flush of a full station with dispatch in the same cycle");
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(TAG_W'(i), 1'b0, '0, 32'h0, 1'b0, '0, 32'h0);
      step();
    end
    checkOutput("refill_count", 32'(count), 32'd16);
    drive_disp(5'd20, 1'b0, '0, 32'h0, 1'b0, '0, 32'h0);
    flush = 1'b1;
    #2;
    checkOutput("flush_disp_ready", 32'(disp_ready), 32'd0);
    checkOutput("flush_iss_valid", 32'(iss_valid), 32'd0);
    step();
    drive_idle();
    checkOutput("post_flush_count", 32'(count), 32'd0);
    checkOutput("post_flush_iss_valid", 32'(iss_valid), 32'd0);
    iss_ready = 1'b1;
    repeat (3) step();
    checkOutput("post_flush_idle_count", 32'(count), 32'd0);

    $display("[TB] asynchronous reset during an issue stall");
    iss_ready = 1'b0;
    drive_disp(5'd1, 1'b0, '0, 32'h1, 1'b0, '0, 32'h2);
    step();
    drive_disp(5'd2, 1'b0, '0, 32'h3, 1'b0, '0, 32'h4);
    step();
    drive_idle();
    #1;
    checkOutput("stall_iss_valid", 32'(iss_valid), 32'd1);
    checkOutput("stall_count", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_iss_valid", 32'(iss_valid), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    iss_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    checkOutput("after_rst_count", 32'(count), 32'd0);
    checkOutput("after_rst_iss_valid", 32'(iss_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_station.md
# rs_station

Parametrised reservation station for the out-of-order core. It sits between decode/rename dispatch and the ALU/branch execution unit. It holds up to DEPTH instructions waiting on operands and captures results from NUM_CDB common-data-bus broadcast ports. It issues the oldest ready entry through a valid/ready handshake. Unlike the single-bus, lowest-index RS, it selects by age, exposes backpressure, and supports multiple CDBs.

## Interface
- DEPTH, 16: number of entries (power of two, 4..64)
- XLEN, 32: operand/value width
- TAG_W, 5: ROB tag width
- OP_W, 6: decoded opcode width
- NUM_CDB, 2: broadcast ports (1..4)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  mispredict clear
- disp_valid / disp_ready  in/out  1  dispatch handshake
- disp_op  in  OP_W;  disp_pc, disp_imm  in  XLEN
- disp_tag  in  TAG_W  destination ROB tag
- disp_qj_v, disp_qk_v  in  1  operand j/k still pending
- disp_qj, disp_qk  in  TAG_W;  disp_vj, disp_vk  in  XLEN
- cdb_valid  in  NUM_CDB;  cdb_tag  in  NUM_CDB*TAG_W;  cdb_value  in  NUM_CDB*XLEN
- iss_valid / iss_ready  out/in  1  issue handshake
- iss_op, iss_vj, iss_vk, iss_imm, iss_pc, iss_tag  out  selected entry fields
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Each entry holds busy, op, pc, imm, tag, and per operand a pending bit, wait tag, and value.
- Dispatch fires when disp_valid && disp_ready; the entry is written into the lowest-index free slot. disp_ready = rdy && !flush && count < DEPTH. A slot freed in the same cycle is not reused.
- Wakeup: for every busy entry and every operand with its pending bit set, a match on any valid CDB port clears the pending bit and latches the value. If several ports match, the lowest port index wins.
- Ready entry: busy with both pending bits clear. Select the oldest ready entry using an age matrix. A new dispatch is younger than all resident entries.
- iss_valid = rdy && !flush && any ready entry. The iss_* fields are combinational from the selected entry. On iss_valid && iss_ready the entry's busy bit clears at the edge.
- iss_* fields hold while iss_valid && !iss_ready unless an older entry becomes ready. Consumers must not assume stability across a stall.
- flush clears every busy bit and the age matrix next edge. It dominates dispatch and issue in the same cycle.
- rdy=0: no state changes, iss_valid=0, disp_ready=0.
- count increments on dispatch only and decrements on issue only. It is unchanged when both fire.

## Timing
- Reset values: count=0, iss_valid=0, disp_ready=1 once rdy=1, all iss_* fields 0. All entries not busy, pending bits clear.
- Dispatch with no pending operands in cycle N → earliest iss_valid in cycle N+1.
- CDB match in cycle N → pending bit clear at edge N → earliest issue in cycle N+1.
- Reset asserted mid-operation clears immediately and asynchronously; no issue completes that cycle.
- Full: count==DEPTH → disp_ready=0. Empty: iss_valid=0.

## Configuration
- RS_CDB_BYPASS_EN defined: dispatch-cycle CDB capture. If a dispatching operand is pending and its tag matches a valid CDB port in the same cycle, it is stored as ready with the CDB value. Such an entry can issue at N+1.
- RS_CDB_BYPASS_EN undefined: no dispatch-cycle capture. Decode/ROB must forward same-cycle broadcasts before dispatch, or the operand misses the wakeup.

## Structure
- rs_pkg: entry typedef, opcode constants (including JALR), and the localparam for count width.
- Sub-module rs_age_matrix (DEPTH×DEPTH bits):
  - inputs: allocate index/valid, free mask, ready mask, clear
  - output: one-hot oldest ready entry

## Test plan
- Fill 16 independent entries (qj_v=qk_v=0, tags 0..15) with iss_ready=0 → count=16, disp_ready=0. Raise iss_ready → issue order is tags 0,1,…,15, one per cycle.
- Dispatch tag 3 waiting on qj=7, then tag 4 ready → tag 4 issues first. Later, CDB port1 with tag 7, value 0x1234 → next cycle tag 3 issues with iss_vj=0x1234.
- Same tag 9 on both CDB ports, values 0xA / 0xB → operand latches 0xA.
- With RS_CDB_BYPASS_EN: dispatch qk=5 in the same cycle as a CDB tag 5 broadcast with value 0x55 → issues next cycle with vk=0x55. Without the macro, the entry never issues.
- Full station plus same-cycle flush and disp_valid → next cycle count=0, iss_valid=0, nothing written.
- rst driven low mid-stall (iss_valid=1, iss_ready=0) → iss_valid=0 and count=0 immediately, without waiting for a clock edge.
